// File: rtl/ap_mult_pkg.sv
// ap_mult_pkg
//   Shared definitions for the approximate-multiplier round-robin scheduler.
//   DEF_NREQ / DEF_W are the default requester count and operand width. The
//   response record ap_rsp_t is sized from these defaults, so an instance
//   overriding NREQ or W must be paired with matching package values.
package ap_mult_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 8;
  localparam int ID_W     = $clog2(DEF_NREQ);

  // One result as it travels through the product pipeline and the FIFO.
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [2*DEF_W-1:0] p;
  } ap_rsp_t;

endpackage

// File: rtl/ap_mult_rsp_fifo.sv
// ap_mult_rsp_fifo
//   Synchronous FIFO of ap_rsp_t results with a combinational head.
//   While empty, o_rd_data keeps showing the last entry that was popped
//   (zero after reset), so the consumer-facing outputs never glitch to stale
//   storage contents.
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (empties the FIFO)
//   i_push     write i_wr_data (ignored when full)
//   i_wr_data  entry to write
//   i_pop      remove head entry (ignored when empty)
//   o_rd_data  head entry, or last popped entry while empty
//   o_full     DEPTH entries held
//   o_empty    no entries held
//   o_count    number of entries held
module ap_mult_rsp_fifo
  import ap_mult_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  ap_rsp_t          i_wr_data,
  input  logic             i_pop,
  output ap_rsp_t          o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  ap_rsp_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  ap_rsp_t          r_last;
  logic             w_push;
  logic             w_pop;

  // Indices wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  assign o_rd_data = o_empty ? r_last : r_mem[r_rd_ptr];

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ap_mult_rr_sched.sv
// ap_mult_rr_sched
//   Round-robin scheduler sharing one external combinational approximate
//   multiplier core among NREQ requesters. The winner's operands are
//   registered onto core_a/core_b, the product is captured with the requester
//   ID and delayed through LAT-1 stages, then written into a response FIFO.
//   A credit counter (outstanding) admits at most FIFO_DEPTH operations in
//   flight, so no result is ever dropped under rsp_ready backpressure.
// Configuration macro
//   AP_MULT_EXACT_EN  adds req_exact; an accepted operation with its exact bit
//                     set takes core_a*core_b instead of core_p in stage 1.
// Ports
//   clk, rst_n            clock (rising) / asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake, at most one ready bit high
//   req_a, req_b          packed operands, requester i in bits [i*W +: W]
//   req_exact             (AP_MULT_EXACT_EN only) per-requester exact select
//   core_a, core_b        registered operands to the approximate core
//   core_p                combinational core product
//   rsp_valid/rsp_ready   response handshake, rsp_id/rsp_p = FIFO head
//   busy                  at least one operation outstanding
module ap_mult_rr_sched
  import ap_mult_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int W          = DEF_W,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
`ifdef AP_MULT_EXACT_EN
  input  logic [NREQ-1:0]   req_exact,
`endif
  output logic [W-1:0]      core_a,
  output logic [W-1:0]      core_b,
  input  logic [2*W-1:0]    core_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [2*W-1:0]    rsp_p,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = ID_W + 1;

  logic [2*NREQ-1:0] w_req_dbl;
  logic [NREQ-1:0]   w_req_rot;
  logic              w_grant_vld;
  logic [ID_W-1:0]   w_grant_off;
  logic [SUM_W-1:0]  w_grant_sum;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_can_accept;
  logic              w_accept;
  logic              w_pop;
  logic [W-1:0]      w_op_a [NREQ];
  logic [W-1:0]      w_op_b [NREQ];
  logic [2*W-1:0]    w_prod;

  logic [ID_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_outst;
  logic [W-1:0]      r_core_a;
  logic [W-1:0]      r_core_b;
  logic              r_op_vld;
  logic [ID_W-1:0]   r_op_id;
  logic [LAT-1:1]    r_stg_vld;
  ap_rsp_t           r_stg [1:LAT-1];

  ap_rsp_t           w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_unused_fifo;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op_a[gi] = req_a[gi*W +: W];
    assign w_op_b[gi] = req_b[gi*W +: W];
  end

  // Rotate the request vector so bit 0 is the requester at the pointer;
  // the lowest set bit of the rotated vector is the round-robin winner.
  assign w_req_dbl = {req_valid, req_valid} >> r_ptr;
  assign w_req_rot = w_req_dbl[NREQ-1:0];

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_grant_vld = 1'b1;
        w_grant_off = ID_W'(j);
      end
    end
  end

  assign w_grant_sum = {1'b0, r_ptr} + {1'b0, w_grant_off};
  assign w_grant_idx = (w_grant_sum >= SUM_W'(NREQ)) ?
                       ID_W'(w_grant_sum - SUM_W'(NREQ)) : w_grant_sum[ID_W-1:0];

  // Credits are checked against the registered count only, so a pop in the
  // same cycle never frees a slot for an accept in that cycle.
  assign w_can_accept = (r_outst < CNT_W'(FIFO_DEPTH));
  assign w_accept     = w_grant_vld & w_can_accept;
  assign req_ready    = w_accept ? (NREQ'(1) << w_grant_idx) : '0;
  assign w_pop        = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_core_a <= '0;
      r_core_b <= '0;
      r_op_vld <= 1'b0;
      r_op_id  <= '0;
      r_outst  <= '0;
    end else begin
      r_op_vld <= w_accept;
      if (w_accept) begin
        r_ptr    <= (w_grant_idx == ID_W'(NREQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
        r_core_a <= w_op_a[w_grant_idx];
        r_core_b <= w_op_b[w_grant_idx];
        r_op_id  <= w_grant_idx;
      end
      case ({w_accept, w_pop})
        2'b10:   r_outst <= r_outst + CNT_W'(1);
        2'b01:   r_outst <= r_outst - CNT_W'(1);
        default: ;
      endcase
    end
  end

`ifdef AP_MULT_EXACT_EN
  logic           r_op_exact;
  logic [2*W-1:0] w_exact;

  assign w_exact = {{W{1'b0}}, r_core_a} * {{W{1'b0}}, r_core_b};
  assign w_prod  = r_op_exact ? w_exact : core_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_exact <= 1'b0;
    end else if (w_accept) begin
      r_op_exact <= req_exact[w_grant_idx];
    end
  end
`else
  assign w_prod = core_p;
`endif

  // Stage 1 samples the core one cycle after the operands were registered;
  // stages 2..LAT-1 are pure delay so the FIFO write lands at accept+LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_vld <= '0;
      for (int s = 1; s < LAT; s++) begin
        r_stg[s] <= '0;
      end
    end else begin
      r_stg_vld[1] <= r_op_vld;
      r_stg[1].id  <= r_op_id;
      r_stg[1].p   <= w_prod;
      for (int s = 2; s < LAT; s++) begin
        r_stg_vld[s] <= r_stg_vld[s-1];
        r_stg[s]     <= r_stg[s-1];
      end
    end
  end

  ap_mult_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (r_stg_vld[LAT-1]),
    .i_wr_data (r_stg[LAT-1]),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // The credit counter already bounds occupancy; the FIFO status is not needed.
  assign w_unused_fifo = w_fifo_full ^ (^w_fifo_count);

  assign core_a    = r_core_a;
  assign core_b    = r_core_b;
  assign rsp_valid = ~w_fifo_empty;
  assign rsp_id    = w_head.id;
  assign rsp_p     = w_head.p;
  assign busy      = (r_outst != '0);

endmodule

// File: tb/tb_ap_mult_rr_sched.sv
// tb_ap_mult_rr_sched
//   Directed bench for ap_mult_rr_sched. The core is modelled as an exact
//   multiplier (optionally corrupted to prove the exact-fallback path).
//   Expected responses are queued at accept time; a monitor pops and compares
//   whenever a response is handed over.
module tb_ap_mult_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
`ifdef AP_MULT_EXACT_EN
  logic [3:0]  req_exact;
`endif
  logic [7:0]  core_a;
  logic [7:0]  core_b;
  logic [15:0] core_p;
  logic        core_corrupt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_p;
  logic        busy;

  typedef struct {
    int id;
    int p;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rsp    = 0;

  // Hand-computed products for each requester in the streaming tests.
  int p2[4] = '{15, 143, 400, 65025};
  int p3[4] = '{68, 10000, 0, 256};

  always #5 clk = ~clk;

  assign core_p = core_corrupt ? 16'hDEAD : ({8'd0, core_a} * {8'd0, core_b});

  ap_mult_rr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef AP_MULT_EXACT_EN
    .req_exact (req_exact),
`endif
    .core_a    (core_a),
    .core_b    (core_b),
    .core_p    (core_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*8 +: 8] = 8'(a);
    req_b[i*8 +: 8] = 8'(b);
  endtask

  // Called at a negedge with inputs set: report which requester (or -1) is
  // accepted at the coming posedge, then advance to the next negedge.
  task automatic step(output int g);
    #1;
    g = -1;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) g = i;
    end
    @(negedge clk);
  endtask

  task automatic grant_is(input string name, input int g, input int exp_g, input int exp_p);
    exp_t e;
    chk(name, g, exp_g);
    e.id = exp_g;
    e.p  = exp_p;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: samples between the input-drive point and the next active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: got id=%0d p=%0d, required no response", rsp_id, rsp_p);
        end else begin
          e = exp_q.pop_front();
          $display("rsp %0d: id=%0d p=%0d (expect id=%0d p=%0d)", n_rsp, rsp_id, rsp_p, e.id, e.p);
          chk("rsp_id", int'(rsp_id), e.id);
          chk("rsp_p", int'(rsp_p), e.p);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    rsp_ready    = 1'b1;
    core_corrupt = 1'b0;
`ifdef AP_MULT_EXACT_EN
    req_exact    = '0;
`endif
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_core_a", int'(core_a), 0);
    chk("rst_core_b", int'(core_b), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_p", int'(rsp_p), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single request, latency and hold-after-pop.
    set_op(1, 13, 11);
    req_valid = 4'b0010;
    step(g);
    grant_is("t1_grant", g, 1, 143);
    req_valid = '0;
    chk("t1_core_a", int'(core_a), 13);
    chk("t1_core_b", int'(core_b), 11);
    chk("t1_busy", int'(busy), 1);
    chk("t1_vld_k", int'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_vld_k1", int'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_vld_k2", int'(rsp_valid), 1);
    chk("t1_id", int'(rsp_id), 1);
    chk("t1_p", int'(rsp_p), 143);
    @(negedge clk);
    chk("t1_vld_popped", int'(rsp_valid), 0);
    chk("t1_p_hold", int'(rsp_p), 143);
    chk("t1_id_hold", int'(rsp_id), 1);
    chk("t1_core_a_hold", int'(core_a), 13);
    chk("t1_busy_end", int'(busy), 0);

    // 2: all requesters continuously valid, no backpressure.
    do_reset();
    set_op(0, 3, 5);
    set_op(1, 13, 11);
    set_op(2, 200, 2);
    set_op(3, 255, 255);
    req_valid = 4'hF;
    for (int j = 0; j < 12; j++) begin
      step(g);
      grant_is($sformatf("t2_grant%0d", j), g, j % 4, p2[j % 4]);
    end
    req_valid = '0;
    drain("t2_drain");

    // 3: credit exhaustion, no same-cycle credit reuse, resume after pop.
    do_reset();
    rsp_ready = 1'b0;
    set_op(0, 17, 4);
    set_op(1, 100, 100);
    set_op(2, 0, 99);
    set_op(3, 128, 2);
    req_valid = 4'hF;
    for (int j = 0; j < 4; j++) begin
      step(g);
      grant_is($sformatf("t3_fill%0d", j), g, j, p3[j]);
    end
    step(g);
    chk("t3_block", g, -1);
    chk("t3_ready0", int'(req_ready), 0);
    chk("t3_busy", int'(busy), 1);
    chk("t3_full_vld", int'(rsp_valid), 1);
    step(g);
    chk("t3_block2", g, -1);
    rsp_ready = 1'b1;
    step(g);
    chk("t3_no_reuse", g, -1);
    for (int j = 0; j < 4; j++) begin
      step(g);
      grant_is($sformatf("t3_resume%0d", j), g, j, p3[j]);
    end
    req_valid = '0;
    drain("t3_drain");

    // 4: pointer wrap with a single requester, then pointer position probe.
    do_reset();
    set_op(2, 7, 9);
    req_valid = 4'b0100;
    step(g);
    grant_is("t4_first", g, 2, 63);
    step(g);
    grant_is("t4_wrap", g, 2, 63);
    set_op(0, 6, 6);
    set_op(3, 250, 4);
    req_valid = 4'b1001;
    step(g);
    grant_is("t4_ptr3", g, 3, 1000);
    req_valid = 4'b0001;
    step(g);
    grant_is("t4_ptr0", g, 0, 36);
    req_valid = '0;
    drain("t4_drain");

    // 5: reset with operations outstanding.
    do_reset();
    rsp_ready = 1'b0;
    set_op(0, 9, 9);
    set_op(1, 2, 3);
    set_op(2, 50, 50);
    req_valid = 4'b0111;
    for (int j = 0; j < 3; j++) begin
      step(g);
      grant_is($sformatf("t5_acc%0d", j), g, j, 0);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("t5_busy_pre", int'(busy), 1);
    chk("t5_vld_pre", int'(rsp_valid), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_vld", int'(rsp_valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_id", int'(rsp_id), 0);
    chk("t5_rst_p", int'(rsp_p), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_op(0, 3, 3);
    set_op(1, 4, 4);
    set_op(2, 5, 5);
    set_op(3, 6, 6);
    req_valid = 4'hF;
    #1;
    chk("t5_ptr_reset", int'(req_ready), 1);
    step(g);
    grant_is("t5_after", g, 0, 9);
    req_valid = '0;
    drain("t5_drain");

`ifdef AP_MULT_EXACT_EN
    // 6: exact fallback ignores a corrupted core; non-exact still uses core_p.
    do_reset();
    core_corrupt = 1'b1;
    req_exact    = 4'b0001;
    set_op(0, 255, 255);
    set_op(1, 10, 10);
    req_valid = 4'b0011;
    step(g);
    grant_is("t6_exact", g, 0, 65025);
    step(g);
    grant_is("t6_core", g, 1, 57005);
    req_valid = '0;
    drain("t6_drain");
    core_corrupt = 1'b0;
    req_exact    = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
